psum_sched_layer7: RTL and testbench

- Sequences the layer-7 partial-sum accumulator across the weight-group passes needed for one output pixel.
- 512 channels × 32 macros, with 8 macros summed per pass, gives PASS_NUM = 4 passes.
- For each pass: issues a macro-group read, forwards the decoder's data-valid as the accumulator's data_e, and drives the accumulator's chs_macro code with the required one-cycle skew.
- Sits between the layer-7 wrapper (pixel start) and the decoder / partial-sum accumulator pair.

---
 rtl/psum_pkg.sv | 12 +
 rtl/psum_sched_layer7_if.sv | 23 ++
 rtl/psum_tmo_cnt.sv | 18 +
 rtl/psum_sched_layer7.sv | 79 +++++++
 tb/tb_psum_sched_layer7.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/psum_pkg.sv
// psum_pkg: shared state encoding, accumulator chs_macro codes and error flag positions.
package psum_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
    localparam logic [1:0] CHS_INIT = 2'b01;
    localparam logic [1:0] CHS_ACC  = 2'b10;
    localparam logic [1:0] CHS_LAST = 2'b00;
    localparam int ERR_UNEXP = 0;
    localparam int ERR_TMO   = 1;
    function automatic logic [1:0] chs_code(input int k, input int pass_num);
        return k == 0 ? CHS_INIT : k == pass_num - 1 ? CHS_LAST : CHS_ACC;
    endfunction
endpackage

// File: rtl/psum_sched_layer7_if.sv
// psum_sched_layer7_if: pixel start, decoder and accumulator handshake bundle.
interface psum_sched_layer7_if #(parameter int GW = 2);
    logic          mode;
    logic          start;
    logic          start_ready;
    logic          macro_req;
    logic [GW-1:0] macro_grp;
    logic          dec_valid;
    logic          ps_data_e;
    logic [1:0]    ps_chs_macro;
    logic          psum_valid;
    logic          pix_done;
    logic          busy;
    logic [1:0]    err;
    modport master (
        output mode, start, dec_valid, psum_valid,
        input  start_ready, macro_req, macro_grp, ps_data_e, ps_chs_macro, pix_done, busy, err
    );
    modport slave (
        input  mode, start, dec_valid, psum_valid,
        output start_ready, macro_req, macro_grp, ps_data_e, ps_chs_macro, pix_done, busy, err
    );
endinterface

// File: rtl/psum_tmo_cnt.sv
// psum_tmo_cnt: loadable down-counter; expire is high once TMO-1 cycles have elapsed since load.
module psum_tmo_cnt #(
    parameter int TMO = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);
    localparam int W = $clog2(TMO + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= W'(TMO - 1);
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expire = cnt == '0;
endmodule

// File: rtl/psum_sched_layer7.sv
// psum_sched_layer7: steps the layer-7 partial-sum accumulator through PASS_NUM macro-group
// passes per pixel, forwarding decoder valids as data_e with chs_macro skewed one cycle later.
module psum_sched_layer7
    import psum_pkg::*;
#(
    parameter int PASS_NUM = 4,
    parameter int GW       = 2,
    parameter int TMO      = 64
) (
    input logic                clk,
    input logic                rst,
    psum_sched_layer7_if.slave bus
);
    state_t        state;
    logic [GW-1:0] k;
    logic [1:0]    chs;
    logic [1:0]    err;
    logic          pix_done;
    logic          accept;
    logic          take;
    logic          last;
    logic          expire;
    assign bus.start_ready  = state == IDLE && bus.mode && !pix_done && !rst;
    assign bus.macro_req    = state == REQ && bus.mode;
    assign bus.ps_data_e    = take;
    assign bus.macro_grp    = k;
    assign bus.ps_chs_macro = chs;
    assign bus.pix_done     = pix_done;
    assign bus.busy         = state != IDLE;
    assign bus.err          = err;
    assign accept = bus.start && bus.start_ready;
    assign take   = state == WAIT && bus.mode && bus.dec_valid;
    assign last   = k == GW'(PASS_NUM - 1);
    // Each pass is timed from its REQ cycle; the final take re-arms the counter for DRAIN.
    psum_tmo_cnt #(.TMO(TMO)) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .load   (accept || take),
        .expire (expire)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            chs      <= CHS_INIT;
            err      <= '0;
            pix_done <= 1'b0;
        end else begin
            pix_done <= state == DRAIN && bus.mode && bus.psum_valid;
            if (bus.dec_valid && state != WAIT) err[ERR_UNEXP] <= 1'b1;
            if (bus.psum_valid && state != DRAIN) err[ERR_UNEXP] <= 1'b1;
            if (take) chs <= chs_code(int'(k), PASS_NUM);
            if (!bus.mode) begin
                state <= IDLE;
                k     <= '0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        state <= REQ;
                        k     <= '0;
                    end
                    REQ: state <= WAIT;
                    WAIT: if (bus.dec_valid) begin
                        state <= last ? DRAIN : REQ;
                        k     <= last ? k : k + 1'b1;
                    end else if (expire) begin
                        err[ERR_TMO] <= 1'b1;
                        state        <= IDLE;
                    end
                    DRAIN: if (bus.psum_valid) state <= IDLE;
                    else if (expire) begin
                        err[ERR_TMO] <= 1'b1;
                        state        <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_psum_sched_layer7.sv
// tb_psum_sched_layer7: scoreboard bench; stimulus queues expected groups, chs codes and
// pixel completions, and a negedge monitor pops and compares as the DUT presents them.
module tb_psum_sched_layer7;
    localparam int PASS_NUM = 4;
    localparam int TMO      = 64;
    logic clk = 0;
    logic rst = 1;
    psum_sched_layer7_if #(.GW(2)) bus ();
    psum_sched_layer7 #(.PASS_NUM(PASS_NUM), .GW(2), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_grp[$];
    logic [1:0] exp_chs[$];
    int exp_done = 0;
    int de_cyc[$];
    bit chs_pend = 0;
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask
    task automatic unexp(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event, want none (t=%0t)", nm, $time);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [1:0] ref_code(input int p);
        if (p == 0) return 2'b01;
        if (p == PASS_NUM - 1) return 2'b00;
        return 2'b10;
    endfunction
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (rst) chs_pend = 0;
        else begin
            if (chs_pend) begin
                if (exp_chs.size() > 0) chk("chs_macro", int'(bus.ps_chs_macro), int'(exp_chs.pop_front()));
                else unexp("chs_extra");
            end
            chs_pend = bus.ps_data_e;
            if (bus.macro_req) begin
                if (exp_grp.size() > 0) chk("macro_grp", int'(bus.macro_grp), exp_grp.pop_front());
                else unexp("macro_req");
            end
            if (bus.ps_data_e) de_cyc.push_back(cyc);
            if (bus.pix_done) begin
                if (exp_done > 0) begin
                    exp_done--;
                    checks++;
                end else unexp("pix_done");
            end
        end
    end
    task automatic wait_req();
        int n = 0;
        while (!bus.macro_req && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) unexp("macro_req_timeout");
    endtask
    task automatic pixel(input int lat, input int drop, input int pdly, input bit abort);
        int ng = drop < 0 ? PASS_NUM : drop + 1;
        int nc = drop < 0 ? PASS_NUM : drop;
        for (int p = 0; p < ng; p++) exp_grp.push_back(p);
        for (int p = 0; p < nc; p++) exp_chs.push_back(ref_code(p));
        if (drop < 0 && !abort) exp_done++;
        de_cyc.delete();
        chk("start_ready_pre", int'(bus.start_ready), 1);
        bus.start = 1;
        step();
        bus.start = 0;
        chk("req_latency", int'(bus.macro_req), 1);
        for (int p = 0; p < PASS_NUM; p++) begin
            wait_req();
            if (p == drop) begin
                repeat (TMO - 1) step();
                chk("err_before_tmo", int'(bus.err), 0);
                step();
                chk("err_tmo", int'(bus.err), 2);
                chk("busy_tmo", int'(bus.busy), 0);
                repeat (3) step();
                return;
            end
            repeat (1 + lat) step();
            bus.dec_valid = 1;
            step();
            bus.dec_valid = 0;
        end
        chk("busy_drain", int'(bus.busy), 1);
        if (abort) begin
            step();
            rst = 1;
            #1;
            chk("rst_chs", int'(bus.ps_chs_macro), 1);
            chk("rst_req", int'(bus.macro_req), 0);
            chk("rst_de", int'(bus.ps_data_e), 0);
            chk("rst_done", int'(bus.pix_done), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_ready", int'(bus.start_ready), 0);
            chk("rst_err", int'(bus.err), 0);
            step();
            rst = 0;
            repeat (5) step();
            return;
        end
        repeat (pdly - 1) step();
        bus.psum_valid = 1;
        step();
        bus.psum_valid = 0;
        chk("pix_done", int'(bus.pix_done), 1);
        chk("busy_after", int'(bus.busy), 0);
        chk("ready_same", int'(bus.start_ready), 0);
        step();
        chk("ready_next", int'(bus.start_ready), 1);
        chk("pix_done_pulse", int'(bus.pix_done), 0);
    endtask
    task automatic post(input int lat);
        for (int i = 1; i < de_cyc.size(); i++) chk("de_gap", de_cyc[i] - de_cyc[i-1], lat + 2);
        chk("grp_left", exp_grp.size(), 0);
        chk("chs_left", exp_chs.size(), 0);
        chk("done_left", exp_done, 0);
    endtask
    task automatic do_reset();
        rst = 1;
        repeat (2) step();
        rst = 0;
        step();
    endtask
    initial begin
        int lat;
        bus.mode = 1;
        bus.start = 0;
        bus.dec_valid = 0;
        bus.psum_valid = 0;
        repeat (3) step();
        chk("reset_chs", int'(bus.ps_chs_macro), 1);
        chk("reset_err", int'(bus.err), 0);
        chk("reset_ready", int'(bus.start_ready), 0);
        chk("reset_busy", int'(bus.busy), 0);
        rst = 0;
        step();
        pixel(3, -1, 2, 0);
        post(3);
        pixel(0, -1, 2, 0);
        post(0);
        chk("err_clean", int'(bus.err), 0);
        pixel(1, 2, 2, 0);
        post(1);
        do_reset();
        step();
        bus.dec_valid = 1;
        #1;
        chk("spur_de", int'(bus.ps_data_e), 0);
        step();
        bus.dec_valid = 0;
        chk("spur_err", int'(bus.err), 1);
        pixel(2, -1, 3, 0);
        post(2);
        chk("spur_err_sticky", int'(bus.err), 1);
        do_reset();
        exp_grp.push_back(0);
        exp_grp.push_back(1);
        exp_chs.push_back(2'b01);
        bus.start = 1;
        step();
        bus.start = 0;
        step();
        bus.dec_valid = 1;
        step();
        bus.dec_valid = 0;
        step();
        bus.mode = 0;
        bus.dec_valid = 1;
        #1;
        chk("mode_de", int'(bus.ps_data_e), 0);
        step();
        bus.dec_valid = 0;
        chk("mode_busy", int'(bus.busy), 0);
        chk("mode_ready", int'(bus.start_ready), 0);
        step();
        chk("mode_ready_hold", int'(bus.start_ready), 0);
        bus.mode = 1;
        #1;
        chk("mode_ready_back", int'(bus.start_ready), 1);
        step();
        pixel(1, -1, 2, 0);
        post(1);
        pixel(2, -1, 0, 1);
        post(2);
        for (int i = 0; i < 8; i++) begin
            lat = $urandom_range(0, 6);
            pixel(lat, -1, $urandom_range(1, 5), 0);
            post(lat);
        end
        chk("err_final", int'(bus.err), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end
endmodule
